// File: rtl/delay_line_cfg.sv
// Multi-lane, valid-tagged, stallable delay line with a run-time programmable depth.
// The output tap selects stage[depth-1]; depth changes are only accepted on an empty window.
module delay_line_cfg #(
  parameter int unsigned DWIDTH        = 12,
  parameter int unsigned LANES         = 2,
  parameter int unsigned MAX_DEPTH     = 8,
  parameter int unsigned DEFAULT_DEPTH = 3,
  parameter int unsigned CW            = $clog2(MAX_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    valid_i,
  input  logic [LANES*DWIDTH-1:0] data_i,
  input  logic                    flush_i,
  input  logic                    cfg_we_i,
  input  logic [CW-1:0]           cfg_depth_i,
  output logic                    valid_o,
  output logic [LANES*DWIDTH-1:0] data_o,
  output logic [CW-1:0]           depth_o,
  output logic [CW-1:0]           count_o,
  output logic                    cfg_err_o
);

  localparam int unsigned IW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam int unsigned W  = LANES * DWIDTH;

  logic [W-1:0]         data_q [MAX_DEPTH];
  logic [W-1:0]         data_d [MAX_DEPTH];
  logic [MAX_DEPTH-1:0] valid_q, valid_d;
  logic [CW-1:0]        depth_q, depth_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 cfg_err_q, cfg_err_d;

  logic [IW-1:0] tap_idx;
  logic          depth_ok;
  logic          cfg_acc;
  logic          push;
  logic          pop;

  assign tap_idx = IW'(depth_q - CW'(1));
  assign valid_o = valid_q[tap_idx];
  assign data_o  = data_q[tap_idx];

  assign push = en_i & valid_i;
  assign pop  = en_i & valid_o;

  // A new depth is only safe when nothing is in the window, unless flush empties it anyway.
  assign depth_ok = (cfg_depth_i != '0) && (cfg_depth_i <= CW'(MAX_DEPTH));
  assign cfg_acc  = cfg_we_i && depth_ok && (flush_i || ((count_q == '0) && !push));

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    depth_d   = depth_q;
    count_d   = count_q;
    cfg_err_d = cfg_we_i && !cfg_acc;

    if (flush_i || cfg_acc) begin
      for (int i = 0; i < MAX_DEPTH; i++) begin
        data_d[i] = '0;
      end
      valid_d = '0;
      count_d = '0;
      if (cfg_acc) begin
        depth_d = cfg_depth_i;
      end
    end else if (en_i) begin
      data_d[0]  = data_i;
      valid_d[0] = valid_i;
      for (int i = 1; i < MAX_DEPTH; i++) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < MAX_DEPTH; i++) begin
        data_q[i] <= '0;
      end
      valid_q   <= '0;
      depth_q   <= CW'(DEFAULT_DEPTH);
      count_q   <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      depth_q   <= depth_d;
      count_q   <= count_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign depth_o   = depth_q;
  assign count_o   = count_q;
  assign cfg_err_o = cfg_err_q;

endmodule

// File: tb/tb_delay_line_cfg.sv
// Directed bench for delay_line_cfg: latency, reprogramming, rejects, stall, flush and reset.
module tb_delay_line_cfg;

  localparam int unsigned DWIDTH = 12;
  localparam int unsigned LANES  = 2;
  localparam int unsigned CW     = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    en_i;
  logic                    valid_i;
  logic [LANES*DWIDTH-1:0] data_i;
  logic                    flush_i;
  logic                    cfg_we_i;
  logic [CW-1:0]           cfg_depth_i;
  logic                    valid_o;
  logic [LANES*DWIDTH-1:0] data_o;
  logic [CW-1:0]           depth_o;
  logic [CW-1:0]           count_o;
  logic                    cfg_err_o;

  int errs   = 0;
  int checks = 0;

  delay_line_cfg #(
    .DWIDTH       (DWIDTH),
    .LANES        (LANES),
    .MAX_DEPTH    (8),
    .DEFAULT_DEPTH(3)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en_i),
    .valid_i    (valid_i),
    .data_i     (data_i),
    .flush_i    (flush_i),
    .cfg_we_i   (cfg_we_i),
    .cfg_depth_i(cfg_depth_i),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .depth_o    (depth_o),
    .count_o    (count_o),
    .cfg_err_o  (cfg_err_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] pat(input int k);
    logic [11:0] a;
    logic [11:0] b;
    a = 12'(k * 37 + 1);
    b = 12'(k * 91 + 1280);
    return {a, b};
  endfunction

  task automatic check_idle(input string tag, input logic [CW-1:0] exp_depth);
    check_eq({tag, ".valid"}, 32'(valid_o), 32'd0);
    check_eq({tag, ".data"},  32'(data_o),  32'd0);
    check_eq({tag, ".depth"}, 32'(depth_o), 32'(exp_depth));
    check_eq({tag, ".count"}, 32'(count_o), 32'd0);
    check_eq({tag, ".err"},   32'(cfg_err_o), 32'd0);
  endtask

  task automatic push(input int k);
    valid_i = 1'b1;
    data_i  = pat(k);
    step();
    valid_i = 1'b0;
  endtask

  initial begin
    // Reset with junk on the inputs
    rst = 1'b0; en_i = 1'b1; valid_i = 1'b1; data_i = 24'hFFF_FFF;
    flush_i = 1'b0; cfg_we_i = 1'b0; cfg_depth_i = '0;
    step();
    check_idle("rst_during", 4'd3);
    step();
    rst = 1'b1; valid_i = 1'b0; data_i = '0;
    step();
    check_idle("rst_after", 4'd3);

    // Depth-3 burst: sample k is at the tap right after edge k+2
    for (int k = 0; k < 20; k++) begin
      valid_i = 1'b1;
      data_i  = pat(k);
      step();
      check_eq("burst.count", 32'(count_o), (k + 1 < 3) ? 32'(k + 1) : 32'd3);
      if (k >= 2) begin
        check_eq("burst.valid", 32'(valid_o), 32'd1);
        check_eq("burst.data", 32'(data_o), 32'(pat(k - 2)));
      end else begin
        check_eq("burst.fill", 32'(valid_o), 32'd0);
      end
    end
    valid_i = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step();
      check_eq("drain.count", 32'(count_o), 32'(2 - j));
      check_eq("drain.valid", 32'(valid_o), (j < 2) ? 32'd1 : 32'd0);
      if (j < 2) check_eq("drain.data", 32'(data_o), 32'(pat(18 + j)));
    end

    // Reprogram to 8 on an idle pipeline
    cfg_we_i = 1'b1; cfg_depth_i = 4'd8;
    step();
    cfg_we_i = 1'b0;
    check_eq("cfg8.depth", 32'(depth_o), 32'd8);
    check_eq("cfg8.err", 32'(cfg_err_o), 32'd0);
    valid_i = 1'b1; data_i = 24'hABC_123;
    step();
    valid_i = 1'b0; data_i = '0;
    check_eq("cfg8.count", 32'(count_o), 32'd1);
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i < 7) begin
        check_eq("cfg8.early", 32'(valid_o), 32'd0);
      end else begin
        check_eq("cfg8.valid", 32'(valid_o), 32'd1);
        check_eq("cfg8.data", 32'(data_o), 32'hABC123);
      end
    end
    step();
    check_eq("cfg8.empty", 32'(count_o), 32'd0);

    // Depth 1: one-cycle latency
    cfg_we_i = 1'b1; cfg_depth_i = 4'd1;
    step();
    cfg_we_i = 1'b0;
    check_eq("cfg1.depth", 32'(depth_o), 32'd1);
    push(50);
    check_eq("cfg1.valid", 32'(valid_o), 32'd1);
    check_eq("cfg1.data", 32'(data_o), 32'(pat(50)));
    check_eq("cfg1.count", 32'(count_o), 32'd1);
    step();
    check_eq("cfg1.gone", 32'(valid_o), 32'd0);
    check_eq("cfg1.count0", 32'(count_o), 32'd0);

    // Out-of-range depths are rejected with a one-cycle pulse
    for (int r = 0; r < 2; r++) begin
      cfg_we_i = 1'b1; cfg_depth_i = (r == 0) ? 4'd0 : 4'd9;
      step();
      cfg_we_i = 1'b0;
      check_eq("rej_range.err", 32'(cfg_err_o), 32'd1);
      check_eq("rej_range.depth", 32'(depth_o), 32'd1);
      step();
      check_eq("rej_range.pulse", 32'(cfg_err_o), 32'd0);
    end

    // Write while two items are in flight at depth 4
    cfg_we_i = 1'b1; cfg_depth_i = 4'd4;
    step();
    cfg_we_i = 1'b0;
    check_eq("cfg4.depth", 32'(depth_o), 32'd4);
    push(60);
    push(61);
    check_eq("busy.count", 32'(count_o), 32'd2);
    cfg_we_i = 1'b1; cfg_depth_i = 4'd2;
    step();
    cfg_we_i = 1'b0;
    check_eq("busy.err", 32'(cfg_err_o), 32'd1);
    check_eq("busy.depth", 32'(depth_o), 32'd4);
    check_eq("busy.count2", 32'(count_o), 32'd2);
    step();
    check_eq("busy.pulse", 32'(cfg_err_o), 32'd0);
    check_eq("busy.out0", 32'(data_o), 32'(pat(60)));
    check_eq("busy.v0", 32'(valid_o), 32'd1);
    step();
    check_eq("busy.out1", 32'(data_o), 32'(pat(61)));
    check_eq("busy.cnt1", 32'(count_o), 32'd1);
    step();
    check_eq("busy.done", 32'(valid_o), 32'd0);
    check_eq("busy.cnt0", 32'(count_o), 32'd0);

    // Stall with three in flight and the head already at the tap
    push(70); push(71); push(72);
    step();
    check_eq("stall.head", 32'(data_o), 32'(pat(70)));
    check_eq("stall.count", 32'(count_o), 32'd3);
    en_i = 1'b0;
    for (int s = 0; s < 5; s++) begin
      valid_i = s[0];
      data_i  = pat(90 + s);
      step();
      check_eq("stall.valid", 32'(valid_o), 32'd1);
      check_eq("stall.data", 32'(data_o), 32'(pat(70)));
      check_eq("stall.cnt", 32'(count_o), 32'd3);
    end
    en_i = 1'b1; valid_i = 1'b0;
    for (int s = 1; s <= 3; s++) begin
      step();
      check_eq("resume.cnt", 32'(count_o), 32'(3 - s));
      if (s < 3) check_eq("resume.data", 32'(data_o), 32'(pat(70 + s)));
      else check_eq("resume.end", 32'(valid_o), 32'd0);
    end

    // Flush, valid input and cfg write together
    push(73); push(74); push(75);
    check_eq("flush.pre", 32'(count_o), 32'd3);
    flush_i = 1'b1; valid_i = 1'b1; data_i = pat(76); cfg_we_i = 1'b1; cfg_depth_i = 4'd5;
    step();
    flush_i = 1'b0; valid_i = 1'b0; cfg_we_i = 1'b0;
    check_idle("flush", 4'd5);
    for (int s = 0; s < 6; s++) begin
      step();
      check_eq("flush.stale", 32'(valid_o), 32'd0);
    end
    check_eq("flush.cnt", 32'(count_o), 32'd0);

    // Reset in the middle of traffic at depth 6
    cfg_we_i = 1'b1; cfg_depth_i = 4'd6;
    step();
    cfg_we_i = 1'b0;
    check_eq("cfg6.depth", 32'(depth_o), 32'd6);
    push(80); push(81); push(82); push(83);
    check_eq("mid.count", 32'(count_o), 32'd4);
    rst = 1'b0; valid_i = 1'b1; data_i = pat(84);
    step();
    rst = 1'b1; valid_i = 1'b0;
    check_idle("mid_rst", 4'd3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/delay_line_cfg.md
Name: delay_line_cfg

Overview:
- Multi-lane, valid-tagged, stallable delay line for the poly-arith datapath, e.g. aligning butterfly operands and twiddles across PE stages.
- Delay depth is programmable at run time (1..MAX_DEPTH); the block supports stall and flush and reports how many items are in flight.
- It generalises the fixed-depth single-lane delay: one instance serves every PE alignment without re-synthesis.

Parameters:
DWIDTH, 12, bits per lane (coefficient width)
LANES, 2, number of parallel lanes delayed in lockstep
MAX_DEPTH, 8, number of physical stages; maximum programmable delay
DEFAULT_DEPTH, 3, depth loaded at reset; must satisfy 1 <= DEFAULT_DEPTH <= MAX_DEPTH
CW, $clog2(MAX_DEPTH+1), width of depth and count fields (derived)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
en_i  in  1  advance enable; 0 = stall, all stages hold
valid_i  in  1  input sample valid, captured only when en_i=1
data_i  in  LANES*DWIDTH  packed lane data; lane k = bits [k*DWIDTH +: DWIDTH]
flush_i  in  1  discard everything in flight
cfg_we_i  in  1  request to load a new depth
cfg_depth_i  in  CW  requested depth
valid_o  out  1  valid tag at the output tap
data_o  out  LANES*DWIDTH  output tap data
depth_o  out  CW  currently active depth
count_o  out  CW  number of valid items inside the active window
cfg_err_o  out  1  one-cycle pulse: cfg write rejected

Behaviour:
- Reset (rst=0 at posedge): all stage data and valid bits = 0; depth_o = DEFAULT_DEPTH; count_o = 0; cfg_err_o = 0. Hence valid_o = 0 and data_o = 0. Reset overrides all other inputs, including mid-operation.
- Priority within a cycle: reset > flush > cfg > shift.
- Shift (en_i=1, no flush):
  - stage0 <= {valid_i, data_i}; stage[i] <= stage[i-1] for all MAX_DEPTH stages.
  - Data is captured regardless of valid_i.
- Output tap is combinational from registers: {valid_o, data_o} = stage[depth_o-1].
  - Latency: a sample captured at edge t appears on data_o after edge t+depth_o-1, i.e. it is visible for the cycle following edge t+depth_o-1 and sampled downstream at edge t+depth_o.
  - With en_i held high, the output equals the input delayed by exactly depth_o cycles.
- Stall (en_i=0): every stage holds; valid_i/data_i are ignored. valid_o and data_o remain stable. An output transfer occurs only on a cycle with en_i=1 and valid_o=1.
- count_o:
  - Next value = count_o + (en_i & valid_i) - (en_i & valid_o).
  - Simultaneous in/out leaves it unchanged.
  - It never exceeds depth_o; it saturates to neither bound by design.
- Flush (flush_i=1): clears all valid bits and all stage data to 0; count_o <= 0. valid_i in the same cycle is discarded. en_i is irrelevant.
- Config write (cfg_we_i=1):
  - Accepted iff cfg_depth_i is in 1..MAX_DEPTH AND (flush_i=1 OR (count_o==0 AND NOT(en_i & valid_i))).
  - On accept: depth_o <= cfg_depth_i; all stage valid bits and data cleared, which removes stale tags beyond the old tap; count_o <= 0; the input that cycle is not captured.
  - On reject: depth_o unchanged; pipeline advances normally per en_i; cfg_err_o = 1 for exactly the next cycle.
  - Depth 0 or depth > MAX_DEPTH is always rejected.
- cfg_err_o is 0 in every cycle not immediately following a rejection.
- Lanes are fully independent in data and share valid/en/flush. Widths are exact; there is no arithmetic on data.

Test Plan:
- Reset/latency: DWIDTH=12, LANES=2, depth 3, en=1, drive valid bursts of 20 random samples → each appears on data_o exactly 3 cycles later with valid_o=1; count_o peaks at 3; outputs are 0 during and right after reset.
- Reprogram: idle pipeline, cfg_we=1, cfg_depth=8 → depth_o=8 next cycle, cfg_err_o=0; sample 0xABC arrives 8 cycles later. Repeat with depth 1 → 1-cycle latency.
- Rejects:
  - cfg_depth=0 → cfg_err_o pulses once, depth_o unchanged.
  - cfg_depth=9 → same.
  - Write while count_o=2 → same, and in-flight data still emerges intact.
- Stall: with 3 items in flight, deassert en_i for 5 cycles while toggling data_i/valid_i → data_o, valid_o and count_o frozen, nothing captured; resuming delivers the original items in order.
- Flush + cfg same cycle: count_o=3, assert flush_i, valid_i and cfg_we (depth 5) → next cycle count_o=0, valid_o=0, depth_o=5, no error; no stale valid ever appears later.
- Reset mid-operation: rst=0 for one cycle with count_o=4, depth 6 → depth_o=3, count_o=0, valid_o=0, data_o=0 immediately after the edge.
